ptmch_cap: RTL and testbench

PTMCH_CAP -- requirements
Module: ptmch_cap

---
 rtl/ptmch_cap.sv | 171 +++++++++++++++++
 tb/tb_ptmch_cap.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ptmch_cap.sv
// SPI mode-0 command capture: decodes page-address and status-register frames and
// publishes the last committed frame plus a toggle for a downstream clock-domain handoff.
module ptmch_cap #(
    parameter logic [7:0] p_program_excute   = 8'h10,
    parameter logic [7:0] p_128kb_blockerase = 8'hd8,
    parameter logic [7:0] p_pagedata_read    = 8'h13,
    parameter logic [7:0] p_readstatus1      = 8'h0f,
    parameter logic [7:0] p_readstatus2      = 8'h05,
    parameter logic [7:0] p_writestatus1     = 8'h1f,
    parameter logic [7:0] p_writestatus2     = 8'h01
) (
    input  logic        SPI_CLK,
    input  logic        RESET_N,
    input  logic        SPI_CS,
    input  logic        SPI_MOSI,
    output logic [7:0]  CAP_OPC,
    output logic [15:0] CAP_ADDR,
    output logic [7:0]  CAP_DATA,
    output logic [1:0]  CAP_CLS,
    output logic        CAP_TGL,
    output logic [7:0]  CAP_CNT,
    output logic [7:0]  UNK_CNT
);

    typedef enum logic [2:0] {S_OPC, S_DMY, S_ADR, S_SDAT, S_HOLD} state_t;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_PAGE = 2'b01;
    localparam logic [1:0] CLS_SRD  = 2'b10;
    localparam logic [1:0] CLS_SWR  = 2'b11;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  frm_opc_q, frm_opc_d;
    logic [1:0]  frm_cls_q, frm_cls_d;
    logic [15:0] frm_adr_q, frm_adr_d;

    logic [7:0]  cap_opc_q;
    logic [15:0] cap_addr_q;
    logic [7:0]  cap_data_q;
    logic [1:0]  cap_cls_q;
    logic        cap_tgl_q;
    logic [7:0]  cap_cnt_q;
    logic [7:0]  unk_cnt_q;

    logic [7:0]  opc_full;
    logic [15:0] word_full;
    logic [15:0] addr_now;
    logic [1:0]  dec_cls;
    logic        last_bit;
    logic        commit;
    logic        unk_hit;

    // The final bit of every field is taken straight from MOSI so commit needs no extra edge.
    assign opc_full  = {shift_q[6:0], SPI_MOSI};
    assign word_full = {shift_q[14:0], SPI_MOSI};
    assign addr_now  = (frm_cls_q == CLS_PAGE) ? word_full : {8'h00, word_full[7:0]};

    always_comb begin
        dec_cls = CLS_NONE;
        if (opc_full == p_program_excute || opc_full == p_128kb_blockerase ||
            opc_full == p_pagedata_read)
            dec_cls = CLS_PAGE;
        else if (opc_full == p_readstatus1 || opc_full == p_readstatus2)
            dec_cls = CLS_SRD;
        else if (opc_full == p_writestatus1 || opc_full == p_writestatus2)
            dec_cls = CLS_SWR;
    end

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            S_OPC, S_DMY, S_SDAT: last_bit = (cnt_q == 5'd7);
            S_ADR:  last_bit = (cnt_q == ((frm_cls_q == CLS_PAGE) ? 5'd15 : 5'd7));
            default: last_bit = 1'b0;
        endcase
    end

    // Gating with SPI_CS keeps a frame that ends on a chip-select release from committing.
    assign commit  = !SPI_CS && last_bit &&
                     ((state_q == S_ADR && frm_cls_q != CLS_SWR) || state_q == S_SDAT);
    assign unk_hit = !SPI_CS && last_bit && state_q == S_OPC && dec_cls == CLS_NONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 5'd1;
        shift_d   = word_full;
        frm_opc_d = frm_opc_q;
        frm_cls_d = frm_cls_q;
        frm_adr_d = frm_adr_q;
        case (state_q)
            S_OPC: if (last_bit) begin
                frm_opc_d = opc_full;
                frm_cls_d = dec_cls;
                cnt_d     = 5'd0;
                if (dec_cls == CLS_PAGE)      state_d = S_DMY;
                else if (dec_cls == CLS_NONE) state_d = S_HOLD;
                else                          state_d = S_ADR;
            end
            S_DMY: if (last_bit) begin
                cnt_d   = 5'd0;
                state_d = S_ADR;
            end
            S_ADR: if (last_bit) begin
                frm_adr_d = addr_now;
                cnt_d     = 5'd0;
                state_d   = (frm_cls_q == CLS_SWR) ? S_SDAT : S_HOLD;
            end
            S_SDAT: if (last_bit) begin
                cnt_d   = 5'd0;
                state_d = S_HOLD;
            end
            default: begin
                cnt_d   = cnt_q;
                shift_d = shift_q;
            end
        endcase
    end

    always_ff @(posedge SPI_CLK or negedge RESET_N or posedge SPI_CS) begin
        if (!RESET_N || SPI_CS) begin
            state_q   <= S_OPC;
            cnt_q     <= 5'd0;
            shift_q   <= 16'h0000;
            frm_opc_q <= 8'h00;
            frm_cls_q <= CLS_NONE;
            frm_adr_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            frm_opc_q <= frm_opc_d;
            frm_cls_q <= frm_cls_d;
            frm_adr_q <= frm_adr_d;
        end
    end

    // Published record survives chip-select; only RESET_N clears it.
    always_ff @(posedge SPI_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cap_opc_q  <= 8'h00;
            cap_addr_q <= 16'h0000;
            cap_data_q <= 8'h00;
            cap_cls_q  <= CLS_NONE;
            cap_tgl_q  <= 1'b0;
            cap_cnt_q  <= 8'h00;
            unk_cnt_q  <= 8'h00;
        end else begin
            if (commit) begin
                cap_opc_q  <= frm_opc_q;
                cap_addr_q <= (state_q == S_SDAT) ? frm_adr_q : addr_now;
                cap_data_q <= (state_q == S_SDAT) ? word_full[7:0] : 8'h00;
                cap_cls_q  <= frm_cls_q;
                cap_tgl_q  <= ~cap_tgl_q;
                cap_cnt_q  <= cap_cnt_q + 8'd1;
            end
            if (unk_hit)
                unk_cnt_q <= unk_cnt_q + 8'd1;
        end
    end

    assign CAP_OPC  = cap_opc_q;
    assign CAP_ADDR = cap_addr_q;
    assign CAP_DATA = cap_data_q;
    assign CAP_CLS  = cap_cls_q;
    assign CAP_TGL  = cap_tgl_q;
    assign CAP_CNT  = cap_cnt_q;
    assign UNK_CNT  = unk_cnt_q;

endmodule

// File: tb/tb_ptmch_cap.sv
// Randomised scoreboard bench for ptmch_cap: a frame-level model queues expected commits,
// a monitor pops them whenever CAP_TGL flips.
module tb_ptmch_cap;

    logic        SPI_CLK = 1'b0;
    logic        RESET_N;
    logic        SPI_CS;
    logic        SPI_MOSI;
    logic [7:0]  CAP_OPC;
    logic [15:0] CAP_ADDR;
    logic [7:0]  CAP_DATA;
    logic [1:0]  CAP_CLS;
    logic        CAP_TGL;
    logic [7:0]  CAP_CNT;
    logic [7:0]  UNK_CNT;

    ptmch_cap dut (
        .SPI_CLK (SPI_CLK),
        .RESET_N (RESET_N),
        .SPI_CS  (SPI_CS),
        .SPI_MOSI(SPI_MOSI),
        .CAP_OPC (CAP_OPC),
        .CAP_ADDR(CAP_ADDR),
        .CAP_DATA(CAP_DATA),
        .CAP_CLS (CAP_CLS),
        .CAP_TGL (CAP_TGL),
        .CAP_CNT (CAP_CNT),
        .UNK_CNT (UNK_CNT)
    );

    always #5 SPI_CLK = ~SPI_CLK;

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [1:0]  cls;
        logic [7:0]  cnt;
        int          edge_no;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int pe_cnt = 0;
    logic prev_tgl = 1'b0;

    logic [7:0]  m_opc, m_data, m_cnt, m_unk;
    logic [15:0] m_addr;
    logic [1:0]  m_cls;
    logic        m_tgl;

    always @(posedge SPI_CLK) pe_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] cls_of(input logic [7:0] o);
        if (o == 8'h10 || o == 8'hd8 || o == 8'h13) return 2'b01;
        if (o == 8'h0f || o == 8'h05) return 2'b10;
        if (o == 8'h1f || o == 8'h01) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_opc = 0; m_addr = 0; m_data = 0; m_cls = 0; m_tgl = 0; m_cnt = 0; m_unk = 0;
    endtask

    // Frame bytes left-aligned in fr; n = rising edges seen with CS low; base = edge count at CS fall.
    task automatic model_frame(input logic [39:0] fr, input int n, input int base);
        logic [7:0] o;
        logic [1:0] c;
        int req;
        exp_t e;
        o = fr[39:32];
        c = cls_of(o);
        req = (c == 2'b01) ? 32 : (c == 2'b10) ? 16 : (c == 2'b11) ? 24 : 8;
        if (c == 2'b00) begin
            if (n >= 8) m_unk = m_unk + 8'd1;
        end else if (n >= req) begin
            m_opc  = o;
            m_cls  = c;
            m_addr = (c == 2'b01) ? fr[23:8] : {8'h00, fr[31:24]};
            m_data = (c == 2'b11) ? fr[23:16] : 8'h00;
            m_cnt  = m_cnt + 8'd1;
            m_tgl  = ~m_tgl;
            e.opc = m_opc; e.addr = m_addr; e.data = m_data; e.cls = m_cls;
            e.cnt = m_cnt; e.edge_no = base + req;
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [39:0] fr, input int n);
        @(negedge SPI_CLK);
        SPI_CS = 1'b0;
        model_frame(fr, n, pe_cnt);
        for (int i = 0; i < n; i++) begin
            SPI_MOSI = fr[39-i];
            @(negedge SPI_CLK);
        end
        SPI_CS   = 1'b1;
        SPI_MOSI = 1'b0;
        @(negedge SPI_CLK);
    endtask

    task automatic check_state(input string name);
        chk({name, "_rec"}, {CAP_OPC, CAP_ADDR, CAP_DATA, CAP_CLS, CAP_TGL},
                            {m_opc, m_addr, m_data, m_cls, m_tgl});
        chk({name, "_cnt"}, CAP_CNT, m_cnt);
        chk({name, "_unk"}, UNK_CNT, m_unk);
    endtask

    always @(negedge SPI_CLK) begin
        if (!RESET_N) prev_tgl = 1'b0;
        else if (CAP_TGL !== prev_tgl) begin
            prev_tgl = CAP_TGL;
            if (q.size() == 0) chk("unexpected_commit", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_rec", {CAP_OPC, CAP_ADDR, CAP_DATA, CAP_CLS, CAP_CNT},
                                  {e.opc, e.addr, e.data, e.cls, e.cnt});
                chk("commit_edge", pe_cnt, e.edge_no);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] fr;
        logic [7:0] ops [8];
        ops[0] = 8'h10; ops[1] = 8'hd8; ops[2] = 8'h13; ops[3] = 8'h0f;
        ops[4] = 8'h05; ops[5] = 8'h1f; ops[6] = 8'h01; ops[7] = 8'h00;
        RESET_N = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0;
        model_reset();
        repeat (2) @(negedge SPI_CLK);
        check_state("reset");
        #2 RESET_N = 1'b1;

        send_frame(40'h13_00_12_34_00, 32); check_state("page_read");
        send_frame(40'h1f_a0_7c_00_00, 24); check_state("status_write");
        send_frame(40'h05_c0_ff_ff_00, 32); check_state("status_read_extra");
        send_frame(40'hd8_00_ab_00_00, 24); check_state("truncated");
        send_frame(40'hd8_00_00_40_00, 32); check_state("erase");
        send_frame(40'h9f_12_34_56_78, 32); check_state("unknown");
        send_frame(40'h1f_a0_00_00_00, 23); check_state("sw_trunc");

        // Reset in the middle of a 10,00,55,aa frame after 20 edges.
        fr = 40'h10_00_55_aa_00;
        @(negedge SPI_CLK);
        SPI_CS = 1'b0;
        for (int i = 0; i < 20; i++) begin
            SPI_MOSI = fr[39-i];
            @(negedge SPI_CLK);
        end
        #2 RESET_N = 1'b0;
        model_reset();
        #1 check_state("async_reset");
        @(negedge SPI_CLK);
        #2 RESET_N = 1'b1;
        model_frame(fr << 20, 12, pe_cnt);
        for (int i = 20; i < 32; i++) begin
            SPI_MOSI = fr[39-i];
            @(negedge SPI_CLK);
        end
        SPI_CS = 1'b1; SPI_MOSI = 1'b0;
        @(negedge SPI_CLK);
        check_state("post_reset_partial");
        send_frame(fr, 32); check_state("post_reset_full");

        for (int k = 0; k < 150; k++) begin
            fr = {ops[$urandom_range(0, 7)], $urandom(), 8'($urandom())};
            if (fr[39:32] == 8'h00) fr[39:32] = 8'($urandom());
            send_frame(fr, $urandom_range(4, 40));
        end
        check_state("random");

        while (m_cnt != 8'h00) send_frame({8'h05, 8'($urandom()), 24'h0}, 16);
        chk("cnt_wrap", CAP_CNT, 8'h00);
        check_state("wrap");

        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
